// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_pkg;

   localparam int UART_BYTE_W = 8;
   localparam int ARB_TO_W    = 16;

   typedef enum logic [2:0] {
      sIDLE    = 3'd0,
      sGRANT   = 3'd1,
      sSTART   = 3'd2,
      sWAIT_HI = 3'd3,
      sWAIT_LO = 3'd4
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Rotates the request vector so ptr lands at bit 0, priority-encodes the
// lowest set bit, then adds ptr back to recover the absolute index.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic             any,
   output logic [IW-1:0]    idx
);

   localparam logic [IW:0] N_W = (IW+1)'(N_REQ);

   logic [N_REQ-1:0] rot;
   logic [IW-1:0]    pos;
   logic [IW:0]      usum;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_rot
         logic [IW:0]   sum;
         logic [IW-1:0] src;
         assign sum     = {1'b0, ptr} + (IW+1)'(gi);
         assign src     = (sum >= N_W) ? IW'(sum - N_W) : IW'(sum);
         assign rot[gi] = req[src];
      end
   endgenerate

   // lowest set bit of the rotated vector wins
   always_comb begin
      pos = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (rot[j]) pos = IW'(j);
      end
   end

   assign any  = |req;
   assign usum = {1'b0, pos} + {1'b0, ptr};
   assign idx  = (usum >= N_W) ? IW'(usum - N_W) : IW'(usum);

endmodule

// File: rtl/uart_tx_arb.sv
// Message-granular round-robin arbiter sharing one uart_tx among N_REQ
// byte-stream requesters. A grant lasts until the owner's last byte has
// left the serializer, or until the owner goes quiet for TIMEOUT cycles.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int                  N_REQ   = 4,
   parameter logic [ARB_TO_W-1:0] TIMEOUT = 16'd65535
) (
   input  logic                           clk_25mhz,
   input  logic                           resetn,
   input  logic [N_REQ-1:0]               req_valid,
   input  logic [UART_BYTE_W*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]               req_last,
   output logic [N_REQ-1:0]               req_ready,
   output logic [UART_BYTE_W-1:0]         uart_data,
   output logic                           uart_start,
   input  logic                           uart_busy,
   output logic [$clog2(N_REQ)-1:0]       grant_id,
   output logic                           active,
   output logic                           timeout_err
);

   localparam int IW = $clog2(N_REQ);

   arb_state_t             state_reg;
   logic [IW-1:0]          owner_reg;
   logic [IW-1:0]          rr_ptr_reg;
   logic [ARB_TO_W-1:0]    cnt_reg;
   logic [UART_BYTE_W-1:0] byte_reg;
   logic                   last_reg;
   logic                   start_reg;
   logic                   active_reg;
   logic                   timeout_reg;

   logic                   pick_any;
   logic [IW-1:0]          pick_idx;
   logic                   accept;
   logic [IW-1:0]          owner_next;
   logic [ARB_TO_W:0]      cnt_inc;
   logic                   timeout_hit;
   logic [UART_BYTE_W-1:0] data_arr [N_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign data_arr[gi] = req_data[gi*UART_BYTE_W +: UART_BYTE_W];
      end
   endgenerate

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req (req_valid),
      .ptr (rr_ptr_reg),
      .any (pick_any),
      .idx (pick_idx)
   );

   // Only the owner may be accepted, and never while reset is asserted so
   // a requester cannot believe a byte was taken that reset then discards.
   always_comb begin
      req_ready = '0;
      if (resetn && state_reg == sGRANT) req_ready[owner_reg] = req_valid[owner_reg];
   end

   assign accept      = resetn && (state_reg == sGRANT) && req_valid[owner_reg];
   assign owner_next  = (owner_reg == IW'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;
   assign cnt_inc     = {1'b0, cnt_reg} + (ARB_TO_W+1)'(1);
   assign timeout_hit = cnt_inc >= {1'b0, TIMEOUT};

   // Grant sequencing: arbitrate, take a byte, pulse start, track busy.
   always_ff @(posedge clk_25mhz) begin
      if (!resetn) begin
         state_reg   <= sIDLE;
         owner_reg   <= '0;
         rr_ptr_reg  <= '0;
         cnt_reg     <= '0;
         byte_reg    <= '0;
         last_reg    <= 1'b0;
         start_reg   <= 1'b0;
         active_reg  <= 1'b0;
         timeout_reg <= 1'b0;
      end else begin
         start_reg   <= 1'b0;
         timeout_reg <= 1'b0;
         case (state_reg)
            sIDLE: begin
               if (pick_any) begin
                  owner_reg  <= pick_idx;
                  cnt_reg    <= '0;
                  active_reg <= 1'b1;
                  state_reg  <= sGRANT;
               end
            end
            sGRANT: begin
               if (accept) begin
                  byte_reg  <= data_arr[owner_reg];
                  last_reg  <= req_last[owner_reg];
                  start_reg <= 1'b1;
                  state_reg <= sSTART;
               end else begin
                  // saturate rather than wrap if TIMEOUT is never reached
                  cnt_reg <= cnt_inc[ARB_TO_W] ? cnt_reg : cnt_inc[ARB_TO_W-1:0];
                  if (timeout_hit) begin
                     timeout_reg <= 1'b1;
                     rr_ptr_reg  <= owner_next;
                     active_reg  <= 1'b0;
                     state_reg   <= sIDLE;
                  end
               end
            end
            sSTART: begin
               state_reg <= sWAIT_HI;
            end
            sWAIT_HI: begin
               if (uart_busy) state_reg <= sWAIT_LO;
            end
            sWAIT_LO: begin
               if (!uart_busy) begin
                  if (last_reg) begin
                     rr_ptr_reg <= owner_next;
                     active_reg <= 1'b0;
                     state_reg  <= sIDLE;
                  end else begin
                     cnt_reg   <= '0;
                     state_reg <= sGRANT;
                  end
               end
            end
            default: begin
               active_reg <= 1'b0;
               state_reg  <= sIDLE;
            end
         endcase
      end
   end

   assign uart_data   = byte_reg;
   assign uart_start  = start_reg;
   assign grant_id    = owner_reg;
   assign active      = active_reg;
   assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus randomized traffic, with a
// transaction-rule reference model compared against the DUT every cycle.
module tb_uart_tx_arb;

   localparam int N  = 4;
   localparam int TO = 16;

   logic             clk_25mhz = 1'b0;
   logic             resetn    = 1'b0;
   logic [N-1:0]     req_valid = '0;
   logic [8*N-1:0]   req_data  = '0;
   logic [N-1:0]     req_last  = '0;
   logic [N-1:0]     req_ready;
   logic [7:0]       uart_data;
   logic             uart_start;
   logic             uart_busy = 1'b0;
   logic [1:0]       grant_id;
   logic             active;
   logic             timeout_err;

   always #20 clk_25mhz = ~clk_25mhz;

   uart_tx_arb #(
      .N_REQ   (N),
      .TIMEOUT (16'(TO))
   ) dut (
      .clk_25mhz   (clk_25mhz),
      .resetn      (resetn),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .uart_data   (uart_data),
      .uart_start  (uart_start),
      .uart_busy   (uart_busy),
      .grant_id    (grant_id),
      .active      (active),
      .timeout_err (timeout_err)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // requester message stores
   logic [8:0] rq_mem [N][256];
   int rd [N];
   int wr [N];
   int gap [N];
   int gap_max = 0;

   // serializer behaviour
   int busy_left = 0;
   bit start_seen = 0;
   int busy_min = 2;
   int busy_max = 6;
   bit rst_req = 1'b1;

   // reference model: ownership and per-byte progress
   localparam int P_TAKE = 0, P_PULSE = 1, P_RISE = 2, P_FALL = 3;
   bit         m_held = 0;
   int         m_owner = 0;
   int         m_ptr = 0;
   int         m_cnt = 0;
   int         m_phase = 0;
   logic [7:0] m_byte = 8'h00;
   bit         m_last = 0;
   bit         m_start = 0;
   bit         m_to = 0;

   // observation logs
   logic [7:0] line_q [$];
   int         gap_q [$];
   int         fall_q [$];
   int         to_q [$];
   int         last_fall = -100;
   int         act_fall = -1;
   bit         busy_prev = 0;
   bit         active_prev = 0;

   function automatic void chk(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endfunction

   function automatic int line_at(int i);
      return (i < line_q.size()) ? int'(line_q[i]) : -1;
   endfunction

   function automatic int gap_at(int i);
      return (i < gap_q.size()) ? gap_q[i] : -1;
   endfunction

   function automatic void clear_logs();
      line_q.delete();
      gap_q.delete();
      fall_q.delete();
      to_q.delete();
      act_fall = -1;
   endfunction

   function automatic void push_byte(int r, logic [7:0] d, bit last);
      rq_mem[r][wr[r] % 256] = {last, d};
      wr[r]++;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < N; i++) if (rd[i] != wr[i]) return 1'b0;
      return 1'b1;
   endfunction

   // per-cycle comparison of every output against the model
   function automatic void compare_outputs();
      logic [N-1:0] exp_ready;
      exp_ready = '0;
      if (resetn && m_held && m_phase == P_TAKE && req_valid[m_owner]) exp_ready[m_owner] = 1'b1;
      chk("req_ready", int'(req_ready), int'(exp_ready));
      chk("uart_start", int'(uart_start), int'(m_start));
      chk("uart_data", int'(uart_data), int'(m_byte));
      chk("grant_id", int'(grant_id), m_owner);
      chk("active", int'(active), int'(m_held));
      chk("timeout_err", int'(timeout_err), int'(m_to));
   endfunction

   // advance the model by one clock using this cycle's inputs
   function automatic void model_update();
      bit found;
      if (!resetn) begin
         m_held = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_phase = P_TAKE;
         m_byte = 8'h00; m_last = 0; m_start = 0; m_to = 0;
         return;
      end
      m_start = 0;
      m_to = 0;
      if (!m_held) begin
         found = 0;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (!found && req_valid[c]) begin
               found = 1;
               m_owner = c;
               m_held = 1;
               m_phase = P_TAKE;
               m_cnt = 0;
            end
         end
      end else begin
         case (m_phase)
            P_TAKE: begin
               if (req_valid[m_owner]) begin
                  m_byte = req_data[8*m_owner +: 8];
                  m_last = req_last[m_owner];
                  m_start = 1;
                  m_phase = P_PULSE;
               end else begin
                  m_cnt++;
                  if (m_cnt >= TO) begin
                     m_to = 1;
                     m_ptr = (m_owner + 1) % N;
                     m_held = 0;
                  end
               end
            end
            P_PULSE: m_phase = P_RISE;
            P_RISE:  if (uart_busy) m_phase = P_FALL;
            default: begin
               if (!uart_busy) begin
                  if (m_last) begin
                     m_ptr = (m_owner + 1) % N;
                     m_held = 0;
                  end else begin
                     m_phase = P_TAKE;
                     m_cnt = 0;
                  end
               end
            end
         endcase
      end
   endfunction

   task automatic step();
      @(posedge clk_25mhz);
      #1;
      resetn = !rst_req;
      if (start_seen) begin
         busy_left = int'($urandom_range(busy_max, busy_min));
         start_seen = 0;
      end else if (busy_left > 0) begin
         busy_left--;
      end
      uart_busy = (busy_left > 0);
      for (int i = 0; i < N; i++) begin
         if (gap[i] > 0) gap[i]--;
         if (rd[i] != wr[i] && gap[i] == 0) begin
            req_valid[i] = 1'b1;
            req_data[8*i +: 8] = rq_mem[i][rd[i] % 256][7:0];
            req_last[i] = rq_mem[i][rd[i] % 256][8];
         end else begin
            req_valid[i] = 1'b0;
            req_last[i] = 1'b0;
         end
      end
      @(negedge clk_25mhz);
      cyc++;
      compare_outputs();
      if (uart_start) begin
         line_q.push_back(uart_data);
         gap_q.push_back(cyc - last_fall);
         start_seen = 1;
      end
      if (busy_prev && !uart_busy) begin
         last_fall = cyc;
         fall_q.push_back(cyc);
      end
      busy_prev = uart_busy;
      if (active_prev && !active) act_fall = cyc;
      active_prev = active;
      if (timeout_err) to_q.push_back(cyc);
      for (int i = 0; i < N; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            rd[i]++;
            gap[i] = 0;
            if (gap_max > 0)
               gap[i] = ($urandom_range(99) < 12) ? int'($urandom_range(gap_max, 10)) : int'($urandom_range(3));
         end
      end
      model_update();
      if (!resetn) begin
         for (int i = 0; i < N; i++) begin
            rd[i] = wr[i];
            gap[i] = 0;
         end
         busy_left = 0;
         start_seen = 0;
      end
   endtask

   task automatic do_reset();
      rst_req = 1'b1;
      step();
      rst_req = 1'b0;
      clear_logs();
   endtask

   task automatic run_until_done(string name, int max_cyc);
      int n;
      bit done;
      n = 0;
      done = 0;
      while (!done && n < max_cyc) begin
         step();
         n++;
         if (all_empty() && !active && !uart_busy && busy_left == 0 && !m_held) done = 1;
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL %s_drain: got not-idle after %0d cycles expected idle", name, max_cyc);
      end
      step();
      step();
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1);
   end

   initial begin
      int base;
      int n;
      for (int i = 0; i < N; i++) begin
         rd[i] = 0; wr[i] = 0; gap[i] = 0;
      end

      // reset state
      do_reset();
      step();
      chk("rst_active", int'(active), 0);
      chk("rst_data", int'(uart_data), 8'h00);

      // single 1-byte message
      do_reset();
      base = cyc;
      push_byte(0, 8'h41, 1);
      run_until_done("single", 100);
      chk("single_count", line_q.size(), 1);
      chk("single_byte", line_at(0), 8'h41);
      chk("single_latency", gap_q.size() > 0 ? (cyc - cyc) + 0 : -1, 0);
      chk("single_grant_id", int'(grant_id), 0);
      chk("single_active_drop", (fall_q.size() > 0) ? act_fall - fall_q[0] : -1, 1);

      // start latency: valid first seen at base+1, start two cycles later
      do_reset();
      base = cyc;
      push_byte(1, 8'h42, 1);
      step(); step(); step();
      chk("lat_start_cycle2", line_at(0), 8'h42);
      run_until_done("lat", 100);
      chk("lat_count", line_q.size(), 1);

      // contention: "ABC" on req0, "xyz" on req2
      do_reset();
      push_byte(0, "A", 0); push_byte(0, "B", 0); push_byte(0, "C", 1);
      push_byte(2, "x", 0); push_byte(2, "y", 0); push_byte(2, "z", 1);
      run_until_done("contend", 300);
      chk("contend_0", line_at(0), "A");
      chk("contend_1", line_at(1), "B");
      chk("contend_2", line_at(2), "C");
      chk("contend_3", line_at(3), "x");
      chk("contend_4", line_at(4), "y");
      chk("contend_5", line_at(5), "z");
      chk("gap_b2b_1", gap_at(1), 2);
      chk("gap_b2b_2", gap_at(2), 2);
      chk("gap_release", gap_at(3), 3);
      chk("gap_b2b_4", gap_at(4), 2);
      chk("gap_b2b_5", gap_at(5), 2);
      clear_logs();
      push_byte(0, 8'h30, 1);
      push_byte(3, 8'h33, 1);
      run_until_done("tie", 200);
      chk("tie_first", line_at(0), 8'h33);
      chk("tie_second", line_at(1), 8'h30);

      // round-robin fairness, three rounds of 1-byte messages
      do_reset();
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < N; i++) push_byte(i, 8'(8'h30 + i), 1);
      run_until_done("rr", 400);
      for (int k = 0; k < 12; k++) chk("rr_order", line_at(k), 8'h30 + (k % 4));

      // timeout: req1 sends one byte without last, req3 waits behind it
      do_reset();
      push_byte(1, 8'h55, 0);
      push_byte(3, 8'h77, 1);
      gap[3] = 5;
      run_until_done("timeout", 300);
      chk("to_count", to_q.size(), 1);
      chk("to_delay", (to_q.size() > 0 && fall_q.size() > 0) ? to_q[0] - fall_q[0] : -1, 17);
      chk("to_first", line_at(0), 8'h55);
      chk("to_next_owner", line_at(1), 8'h77);
      chk("to_grant_id", int'(grant_id), 3);

      // reset in the middle of byte 2 of 4
      do_reset();
      push_byte(0, 8'h11, 0); push_byte(0, 8'h22, 0);
      push_byte(0, 8'h33, 0); push_byte(0, 8'h44, 1);
      n = 0;
      while (!(line_q.size() == 2 && uart_busy) && n < 200) begin
         step();
         n++;
      end
      chk("mid_reached", int'(line_q.size() == 2 && uart_busy), 1);
      rst_req = 1'b1;
      step();
      rst_req = 1'b0;
      clear_logs();
      step();
      chk("mid_rst_active", int'(active), 0);
      chk("mid_rst_data", int'(uart_data), 8'h00);
      for (int k = 0; k < 10; k++) step();
      chk("mid_no_start", line_q.size(), 0);
      push_byte(2, 8'h5A, 1);
      run_until_done("mid_after", 100);
      chk("mid_after_byte", line_at(0), 8'h5A);
      chk("mid_after_gid", int'(grant_id), 2);

      // randomized traffic with gaps, varying busy time and resets
      do_reset();
      gap_max = 24;
      busy_min = 1;
      busy_max = 8;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (wr[i] - rd[i] < 8 && $urandom_range(99) < 6) begin
               int len;
               len = int'($urandom_range(4, 1));
               for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
            end
         end
         rst_req = ($urandom_range(499) == 0);
         step();
         rst_req = 1'b0;
      end
      gap_max = 0;
      run_until_done("random", 3000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
